// File: rtl/fir_pkg.sv
// Shared widths, reset-coefficient rule and saturation helper for the FIR filter.
package fir_pkg;

    localparam int unsigned SAT_W           = 64;
    localparam int unsigned COEF_RST_OFFSET = 1;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] value;
    } sat_t;

    // Sum of TAPS full-width products cannot exceed this width.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic int unsigned coef_rst_val(input int unsigned k);
        return k + COEF_RST_OFFSET;
    endfunction

    // Clamp an unsigned value to out_w bits; out_w must be below SAT_W.
    function automatic sat_t sat_u(input logic [SAT_W-1:0] value,
                                   input int unsigned      out_w);
        sat_t             r;
        logic [SAT_W-1:0] max_v;
        max_v = (SAT_W'(1) << out_w) - SAT_W'(1);
        if (value > max_v) begin
            r.ovf   = 1'b1;
            r.value = max_v;
        end else begin
            r.ovf   = 1'b0;
            r.value = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-writable coefficient register file, reset to k+1, all entries read in parallel.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned TAPS   = 3,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [COEF_W-1:0]      i_data,
    output logic [TAPS*COEF_W-1:0] o_coef_flat
);

    logic [COEF_W-1:0] r_coef [TAPS];

    // Writes to addresses beyond the last tap are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= COEF_W'(coef_rst_val(32'(k)));
            end
        end else if (i_we && (32'(i_addr) < TAPS)) begin
            r_coef[i_addr] <= i_data;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_flat
        assign o_coef_flat[k*COEF_W +: COEF_W] = r_coef[k];
    end

endmodule

// File: rtl/fir_filter_param.sv
// N-tap unsigned direct-form FIR: delay line, registered products, registered
// shift-and-saturate output with overflow flag and a synchronous flush.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 3,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         x,
    input  logic                      clear,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          y,
    output logic                      ovf
);

    localparam int unsigned ADDR_W = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

    logic [TAPS*COEF_W-1:0] w_coef_flat;
    logic [DATA_W-1:0]      r_d [TAPS];
    logic [PROD_W-1:0]      r_p [TAPS];
    logic                   r_v0;
    logic                   r_v1;
    logic [ACC_W-1:0]       w_acc;
    logic [ACC_W-1:0]       w_s;
    sat_t                   w_sat;
    logic                   w_sat_unused;

    fir_coef_bank #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) u_coef_bank (
        .clk         (clk),
        .rst         (rst),
        .i_we        (coef_we),
        .i_addr      (coef_addr),
        .i_data      (coef_data),
        .o_coef_flat (w_coef_flat)
    );

    // Delay line shifts only on accepted samples; clear drops the sample in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
            r_v0 <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= in_valid;
            if (in_valid) begin
                r_d[0] <= x;
                for (int k = 1; k < TAPS; k++) r_d[k] <= r_d[k-1];
            end
        end
    end

    // Stage 1: products use the coefficient value held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) r_p[k] <= '0;
            r_v1 <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) r_p[k] <= '0;
            r_v1 <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                r_p[k] <= PROD_W'(w_coef_flat[k*COEF_W +: COEF_W]) * PROD_W'(r_d[k]);
            end
            r_v1 <= r_v0;
        end
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_acc = w_acc + ACC_W'(r_p[k]);
        end
    end

    assign w_s          = w_acc >> SHIFT;
    assign w_sat        = sat_u(SAT_W'(w_s), OUT_W);
    assign w_sat_unused = ^w_sat.value[SAT_W-1:OUT_W];

    // Stage 2: y/ovf only move on a valid result and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v1;
            if (r_v1) begin
                y   <= OUT_W'(w_sat.value);
                ovf <= w_sat.ovf;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboarded bench for fir_filter_param at SHIFT=0 and SHIFT=3 driven in lockstep.
module tb_fir_filter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] x;
    logic       clear;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_data;
    logic       ov0, ovf0, ov3, ovf3;
    logic [7:0] y0, y3;

    always #5 clk = ~clk;

    fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(3), .OUT_W(8), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov0), .y(y0), .ovf(ovf0)
    );

    fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(3), .OUT_W(8), .SHIFT(3)) dut_s3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov3), .y(y3), .ovf(ovf3)
    );

    typedef struct {
        logic [7:0] y;
        logic       ovf;
        logic [7:0] y3;
        logic       ovf3;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] x;
        logic [7:0] ey;
        logic       eo;
        logic [7:0] ey3;
        logic       eo3;
    } vec_t;

    exp_t q[$];
    vec_t vecs[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input logic v, input logic [7:0] xx, input logic [7:0] ey,
                           input logic eo, input logic [7:0] ey3, input logic eo3);
        vec_t t;
        t.v = v; t.x = xx; t.ey = ey; t.eo = eo; t.ey3 = ey3; t.eo3 = eo3;
        vecs.push_back(t);
    endtask

    // Expected result for the sample driven this cycle: out_valid two edges after acceptance.
    task automatic expect_out(input logic [7:0] ey, input logic eo,
                              input logic [7:0] ey3, input logic eo3);
        exp_t e;
        e.y = ey; e.ovf = eo; e.y3 = ey3; e.ovf3 = eo3; e.cyc = cyc + 3;
        q.push_back(e);
    endtask

    task automatic cycle(input logic v, input logic [7:0] xx, input logic clr,
                         input logic we, input logic [1:0] a, input logic [7:0] d);
        in_valid = v; x = xx; clear = clr; coef_we = we; coef_addr = a; coef_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].v) expect_out(vecs[i].ey, vecs[i].eo, vecs[i].ey3, vecs[i].eo3);
            cycle(vecs[i].v, vecs[i].x, 1'b0, 1'b0, 2'd0, 8'd0);
        end
    endtask

    // Monitor: every out_valid pulse must match the head of the queue, in order and on time.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov0 || ov3) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL spurious_out_valid: got %0b/%0b expected 0 (cycle %0d)", ov0, ov3, cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("out_valid",    32'(ov0),  32'd1);
                    check("out_valid_s3", 32'(ov3),  32'd1);
                    check("y",            32'(y0),   32'(mon_e.y));
                    check("ovf",          32'(ovf0), 32'(mon_e.ovf));
                    check("y_s3",         32'(y3),   32'(mon_e.y3));
                    check("ovf_s3",       32'(ovf3), 32'(mon_e.ovf3));
                    check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end else if (q.size() != 0 && q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                n_checks++;
                n_err++;
                $display("FAIL missing_out_valid: got none expected pulse at cycle %0d", mon_e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; clear = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        // 0..3 impulse, 4..7 step, 8..11 saturation, 12..14 drain
        add_vec(1, 1,   1,   0, 0,   0);
        add_vec(1, 0,   2,   0, 0,   0);
        add_vec(1, 0,   3,   0, 0,   0);
        add_vec(1, 0,   0,   0, 0,   0);
        add_vec(1, 10,  10,  0, 1,   0);
        add_vec(1, 10,  30,  0, 3,   0);
        add_vec(1, 10,  60,  0, 7,   0);
        add_vec(1, 10,  60,  0, 7,   0);
        add_vec(1, 255, 255, 1, 38,  0);
        add_vec(1, 255, 255, 1, 99,  0);
        add_vec(1, 255, 255, 1, 191, 0);
        add_vec(1, 255, 255, 1, 191, 0);
        add_vec(1, 0,   255, 1, 159, 0);
        add_vec(1, 0,   255, 1, 95,  0);
        add_vec(1, 0,   0,   0, 0,   0);
        // 15..18 impulse with coef[2]=0
        add_vec(1, 1,   1,   0, 0,   0);
        add_vec(1, 0,   2,   0, 0,   0);
        add_vec(1, 0,   0,   0, 0,   0);
        add_vec(1, 0,   0,   0, 0,   0);
        // 19..23 gapped stream
        add_vec(1, 4,   4,   0, 0,   0);
        add_vec(0, 0,   0,   0, 0,   0);
        add_vec(0, 0,   0,   0, 0,   0);
        add_vec(1, 0,   8,   0, 1,   0);
        add_vec(0, 0,   0,   0, 0,   0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ov0),  32'd0);
        check("rst_y",         32'(y0),   32'd0);
        check("rst_ovf",       32'(ovf0), 32'd0);
        check("rst_y_s3",      32'(y3),   32'd0);
        rst = 1'b0;
        idle(1);

        run_vecs(0, 14);
        idle(4);

        // coef[2]=0, then an out-of-range write that must be ignored
        cycle(0, 0, 0, 1, 2'd2, 8'd0);
        cycle(0, 0, 0, 1, 2'd3, 8'd99);
        run_vecs(15, 18);
        idle(4);
        cycle(0, 0, 0, 1, 2'd2, 8'd3);

        // coef[0]=5 written on the edge that forms the first sample's products
        expect_out(1,  0, 0, 0); cycle(1, 1, 0, 0, 2'd0, 8'd0);
        expect_out(12, 0, 1, 0); cycle(1, 2, 0, 1, 2'd0, 8'd5);
        expect_out(7,  0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        expect_out(6,  0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        expect_out(0,  0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        cycle(0, 0, 0, 1, 2'd0, 8'd1);
        idle(4);

        run_vecs(19, 23);
        idle(4);

        // clear with in_valid and a coefficient write in the same cycle
        cycle(1, 5, 0, 0, 2'd0, 8'd0);
        cycle(1, 7, 1, 1, 2'd1, 8'd4);
        idle(3);
        check("clear_out_valid", 32'(ov0),  32'd0);
        check("clear_y_held",    32'(y0),   32'd8);
        check("clear_ovf_held",  32'(ovf0), 32'd0);
        check("clear_y_s3_held", 32'(y3),   32'd1);
        expect_out(1, 0, 0, 0); cycle(1, 1, 0, 0, 2'd0, 8'd0);
        expect_out(4, 0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        expect_out(3, 0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        idle(4);

        // asynchronous reset with two samples in flight
        cycle(1, 9, 0, 0, 2'd0, 8'd0);
        cycle(1, 9, 0, 0, 2'd0, 8'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ov0),  32'd0);
        check("midrst_y",         32'(y0),   32'd0);
        check("midrst_ovf",       32'(ovf0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        expect_out(1, 0, 0, 0); cycle(1, 1, 0, 0, 2'd0, 8'd0);
        expect_out(2, 0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        expect_out(3, 0, 0, 0); cycle(1, 0, 0, 0, 2'd0, 8'd0);
        idle(5);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
